// File: rtl/ysyx_22041071_ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, FSM states,
// the sideband bundle carried into EX/MEM, and small op-decode helpers.
package ysyx_22041071_ex_pkg;

  localparam int DIV_STEPS = 64;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SLT   = 5'd3,
    ALU_SLTU  = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_OR    = 5'd8,
    ALU_AND   = 5'd9,
    ALU_ADDW  = 5'd10,
    ALU_SUBW  = 5'd11,
    ALU_SLLW  = 5'd12,
    ALU_SRLW  = 5'd13,
    ALU_SRAW  = 5'd14,
    ALU_MUL   = 5'd15,
    ALU_MULW  = 5'd16,
    ALU_DIV   = 5'd17,
    ALU_DIVU  = 5'd18,
    ALU_REM   = 5'd19,
    ALU_REMU  = 5'd20,
    ALU_DIVW  = 5'd21,
    ALU_DIVUW = 5'd22,
    ALU_REMW  = 5'd23,
    ALU_REMUW = 5'd24
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] rt_data;
    logic [4:0]  rdest;
    logic        mem_w_en;
    logic        wb_sel;
    logic        reg_w_en;
  } ex_side_t;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= ALU_DIV) && (op <= ALU_REMUW);
  endfunction

  function automatic logic div_is_signed(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  endfunction

  function automatic logic div_is_word(input logic [4:0] op);
    return op inside {ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic div_is_rem(input logic [4:0] op);
    return op inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction

endpackage

// File: rtl/ysyx_22041071_divider.sv
// Iterative restoring divider on operand magnitudes; DIV_STEPS steps after start,
// then holds quotient/remainder with sign fixup and RISC-V special cases applied.
module ysyx_22041071_divider
  import ysyx_22041071_ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic        i_word,
  input  logic [63:0] i_dividend,
  input  logic [63:0] i_divisor,
  output logic        o_done,
  output logic [63:0] o_quotient,
  output logic [63:0] o_remainder
);

  logic [63:0]      r_rem, r_quo, r_dvs, r_dvd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_neg_q, r_neg_r, r_zero, r_ovf, r_word;

  logic [63:0] w_dvd_ext, w_dvs_ext, w_dvd_abs, w_dvs_abs;
  logic [64:0] w_shift, w_sub;
  logic        w_ge;
  logic [63:0] w_q, w_r;

  // NOTE: every variable assigned in an always_comb gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_dvd_ext = i_dividend;
    w_dvs_ext = i_divisor;
    if (i_word) begin
      w_dvd_ext = i_signed ? sext32(i_dividend[31:0]) : {32'd0, i_dividend[31:0]};
      w_dvs_ext = i_signed ? sext32(i_divisor[31:0])  : {32'd0, i_divisor[31:0]};
    end
    w_dvd_abs = (i_signed && w_dvd_ext[63]) ? -w_dvd_ext : w_dvd_ext;
    w_dvs_abs = (i_signed && w_dvs_ext[63]) ? -w_dvs_ext : w_dvs_ext;
  end

  // Partial remainder stays below the divisor, so the shifted value fits 65 bits.
  assign w_shift = {r_rem, r_quo[63]};
  assign w_ge    = w_shift >= {1'b0, r_dvs};
  assign w_sub   = w_shift - {1'b0, r_dvs};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_dvd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_word  <= 1'b0;
    end else if (i_start) begin
      r_rem   <= '0;
      r_quo   <= w_dvd_abs;
      r_dvs   <= w_dvs_abs;
      r_dvd   <= w_dvd_ext;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_neg_q <= i_signed && (w_dvd_ext[63] ^ w_dvs_ext[63]);
      r_neg_r <= i_signed && w_dvd_ext[63];
      r_zero  <= (w_dvs_ext == 64'd0);
      r_ovf   <= i_signed && (w_dvd_ext == {1'b1, 63'd0}) && (w_dvs_ext == '1);
      r_word  <= i_word;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_sub[63:0] : w_shift[63:0];
      r_quo <= {r_quo[62:0], w_ge};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_W'(DIV_STEPS - 1)) r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_cnt == CNT_W'(DIV_STEPS - 1));

  always_comb begin
    w_q = r_neg_q ? -r_quo : r_quo;
    w_r = r_neg_r ? -r_rem : r_rem;
    if (r_zero) begin
      w_q = '1;
      w_r = r_dvd;
    end else if (r_ovf) begin
      w_q = r_dvd;
      w_r = '0;
    end
    if (r_word) begin
      w_q = sext32(w_q[31:0]);
      w_r = sext32(w_r[31:0]);
    end
  end

  assign o_quotient  = w_q;
  assign o_remainder = w_r;

endmodule

// File: rtl/ysyx_22041071_ex_stage.sv
// Execute stage: single-cycle ALU/MUL, iterative DIV/REM, and the EX/MEM
// pipeline register with valid/ready handshakes toward ID and MEM.
module ysyx_22041071_ex_stage
  import ysyx_22041071_ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid4,
  output logic        ready4,
  input  logic [63:0] PC4,
  input  logic [31:0] Ins3,
  input  logic [4:0]  alu_op,
  input  logic [63:0] src_a,
  input  logic [63:0] src_b,
  input  logic [63:0] rt_data1,
  input  logic [4:0]  rdest1,
  input  logic        MEM_W_en2,
  input  logic        WB_sel2,
  input  logic        reg_w_en2,
  output logic        valid5,
  input  logic        ready5,
  output logic [63:0] PC5,
  output logic [31:0] Ins4,
  output logic [63:0] rt_data2,
  output logic [4:0]  rdest2,
  output logic [63:0] ALU_result1,
  output logic        MEM_W_en3,
  output logic        WB_sel3,
  output logic        reg_w_en3,
  output logic        ex_busy
);

  ex_state_e   r_state, w_next;
  ex_side_t    r_hold, r_out, w_side_in;
  logic [4:0]  r_h_op;
  logic [63:0] r_result;
  logic        r_valid5;

  logic        w_out_free, w_fire_in, w_start, w_load_alu, w_load_div, w_div_done;
  logic [63:0] w_alu, w_mul, w_quo, w_rem, w_div_res;

  assign w_side_in = '{pc: PC4, ins: Ins3, rt_data: rt_data1, rdest: rdest1,
                       mem_w_en: MEM_W_en2, wb_sel: WB_sel2, reg_w_en: reg_w_en2};

  assign w_out_free = !r_valid5 || ready5;
  assign ready4     = (r_state == S_IDLE) && w_out_free;
  assign w_fire_in  = valid4 && ready4;
  assign w_start    = w_fire_in && is_div_op(alu_op);
  assign w_load_alu = w_fire_in && !is_div_op(alu_op);
  assign w_load_div = (r_state == S_DONE) && w_out_free;

  assign w_mul = src_a * src_b;

  always_comb begin
    w_alu = '0;
    case (alu_op)
      ALU_ADD:  w_alu = src_a + src_b;
      ALU_SUB:  w_alu = src_a - src_b;
      ALU_SLL:  w_alu = src_a << src_b[5:0];
      ALU_SLT:  w_alu = {63'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: w_alu = {63'd0, src_a < src_b};
      ALU_XOR:  w_alu = src_a ^ src_b;
      ALU_SRL:  w_alu = src_a >> src_b[5:0];
      ALU_SRA:  w_alu = $signed(src_a) >>> src_b[5:0];
      ALU_OR:   w_alu = src_a | src_b;
      ALU_AND:  w_alu = src_a & src_b;
      ALU_ADDW: w_alu = sext32(src_a[31:0] + src_b[31:0]);
      ALU_SUBW: w_alu = sext32(src_a[31:0] - src_b[31:0]);
      ALU_SLLW: w_alu = sext32(src_a[31:0] << src_b[4:0]);
      ALU_SRLW: w_alu = sext32(src_a[31:0] >> src_b[4:0]);
      ALU_SRAW: w_alu = sext32($signed(src_a[31:0]) >>> src_b[4:0]);
      ALU_MUL:  w_alu = w_mul;
      ALU_MULW: w_alu = sext32(w_mul[31:0]);
      default:  w_alu = '0;
    endcase
  end

  ysyx_22041071_divider u_divider (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_signed    (div_is_signed(alu_op)),
    .i_word      (div_is_word(alu_op)),
    .i_dividend  (src_a),
    .i_divisor   (src_b),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_div_res = div_is_rem(r_h_op) ? w_rem : w_quo;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start)    w_next = S_BUSY;
      S_BUSY:  if (w_div_done) w_next = S_DONE;
      S_DONE:  if (w_out_free) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A divide keeps its sideband in r_hold so ID may change its outputs meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold   <= '0;
      r_h_op   <= '0;
      r_out    <= '0;
      r_result <= '0;
      r_valid5 <= 1'b0;
    end else begin
      if (w_start) begin
        r_hold <= w_side_in;
        r_h_op <= alu_op;
      end
      if (w_load_alu) begin
        r_out    <= w_side_in;
        r_result <= w_alu;
        r_valid5 <= 1'b1;
      end else if (w_load_div) begin
        r_out    <= r_hold;
        r_result <= w_div_res;
        r_valid5 <= 1'b1;
      end else if (ready5) begin
        r_valid5 <= 1'b0;
      end
    end
  end

  assign valid5      = r_valid5;
  assign PC5         = r_out.pc;
  assign Ins4        = r_out.ins;
  assign rt_data2    = r_out.rt_data;
  assign rdest2      = r_out.rdest;
  assign MEM_W_en3   = r_out.mem_w_en;
  assign WB_sel3     = r_out.wb_sel;
  assign reg_w_en3   = r_out.reg_w_en;
  assign ALU_result1 = r_result;
  assign ex_busy     = (r_state != S_IDLE);

endmodule
